// File: rtl/div_pkg.sv
// Shared types and helpers for the non-restoring divider.
// Contents: FSM state enum, dbz quotient constant, magnitude helper.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2
    } div_state_t;

    // Widest operand the magnitude helper covers; divider WIDTH must not exceed it.
    localparam int unsigned MAX_W = 64;

    // Quotient reported on divide-by-zero (callers truncate to their width).
    localparam logic [MAX_W-1:0] DBZ_QUOTIENT = {MAX_W{1'b1}};

    // Two's-complement magnitude: callers zero-extend the operand, pass whether it
    // is negative in its own width, and truncate the result back to that width.
    function automatic logic [MAX_W-1:0] abs_val(input logic [MAX_W-1:0] v,
                                                 input logic            neg);
        return neg ? (~v + MAX_W'(1)) : v;
    endfunction

endpackage

// File: rtl/nr_div_step.sv
// One combinational non-restoring iteration on the {A,Q} pair.
// Ports: a (WIDTH+1, signed partial remainder), q (WIDTH, dividend/quotient bits),
//        m (WIDTH+1, zero-extended divisor magnitude), a_next_c / q_next_c results.
module nr_div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH:0]   a,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH:0]   m,
    output logic [WIDTH:0]   a_next_c,
    output logic [WIDTH-1:0] q_next_c
);

    logic [WIDTH:0] a_sh;

    // Shift {A,Q} left, add or subtract M by the pre-shift sign of A, then
    // record the new quotient bit as the inverted sign of the result.
    // Overflow out of A's top bit during the shift is harmless: the result is
    // exact modulo 2^(WIDTH+1) and always lands in [-M, M).
    always_comb begin
        a_sh     = {a[WIDTH-1:0], q[WIDTH-1]};
        a_next_c = a[WIDTH] ? (a_sh + m) : (a_sh - m);
        q_next_c = {q[WIDTH-2:0], ~a_next_c[WIDTH]};
    end

endmodule

// File: rtl/nr_divider.sv
// Sequential non-restoring divider, signed/unsigned, WIDTH+1 cycle latency.
// Ports: clk, resetn (async, active-low); start/signed_op/dividend/divisor sampled in IDLE;
//        busy while dividing; done one-cycle pulse; quotient, remainder, div_by_zero
//        registered and held until the next done.
module nr_divider
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    div_state_t       state, state_d;
    logic [WIDTH:0]   a_r, a_d;
    logic [WIDTH-1:0] q_r, q_d;
    logic [WIDTH:0]   m_r, m_d;
    logic [CNT_W-1:0] cnt_r, cnt_d;
    logic             q_neg_r, q_neg_d;
    logic             r_neg_r, r_neg_d;
    logic             dbz_r, dbz_d;
    logic             busy_d, done_d, div_by_zero_d;
    logic [WIDTH-1:0] quotient_d, remainder_d;

    logic [WIDTH:0]   a_step;
    logic [WIDTH-1:0] q_step;
    logic [WIDTH:0]   a_fix;
    logic             neg_a, neg_b;

    nr_div_step #(.WIDTH(WIDTH)) u_step (
        .a        (a_r),
        .q        (q_r),
        .m        (m_r),
        .a_next_c (a_step),
        .q_next_c (q_step)
    );

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_d;
    end

    // Next-state, datapath and output decode.
    always_comb begin
        state_d       = state;
        a_d           = a_r;
        q_d           = q_r;
        m_d           = m_r;
        cnt_d         = cnt_r;
        q_neg_d       = q_neg_r;
        r_neg_d       = r_neg_r;
        dbz_d         = dbz_r;
        busy_d        = busy;
        done_d        = 1'b0;
        quotient_d    = quotient;
        remainder_d   = remainder;
        div_by_zero_d = div_by_zero;
        neg_a         = signed_op & dividend[WIDTH-1];
        neg_b         = signed_op & divisor[WIDTH-1];
        // Remainder restore applies only when the final partial remainder is negative.
        a_fix         = a_r[WIDTH] ? (a_r + m_r) : a_r;

        case (state)
            IDLE: begin
                if (start) begin
                    busy_d = 1'b1;
                    a_d    = '0;
                    cnt_d  = '0;
                    if (divisor == '0) begin
                        // Park the raw dividend in Q; FIX reports it as the remainder.
                        q_d     = dividend;
                        m_d     = '0;
                        q_neg_d = 1'b0;
                        r_neg_d = 1'b0;
                        dbz_d   = 1'b1;
                        state_d = FIX;
                    end else begin
                        q_d     = WIDTH'(abs_val(MAX_W'(dividend), neg_a));
                        m_d     = {1'b0, WIDTH'(abs_val(MAX_W'(divisor), neg_b))};
                        q_neg_d = neg_a ^ neg_b;
                        r_neg_d = neg_a;
                        dbz_d   = 1'b0;
                        state_d = ITER;
                    end
                end
            end
            ITER: begin
                a_d   = a_step;
                q_d   = q_step;
                cnt_d = cnt_r + CNT_W'(1);
                if (cnt_r == CNT_W'(WIDTH - 1)) state_d = FIX;
            end
            FIX: begin
                a_d = a_fix;
                if (dbz_r) begin
                    quotient_d  = WIDTH'(DBZ_QUOTIENT);
                    remainder_d = q_r;
                end else begin
                    // MIN / -1 wraps back to MIN here, which is the intended result.
                    quotient_d  = q_neg_r ? -q_r : q_r;
                    remainder_d = (r_neg_r && (a_fix[WIDTH-1:0] != '0)) ?
                                  -a_fix[WIDTH-1:0] : a_fix[WIDTH-1:0];
                end
                div_by_zero_d = dbz_r;
                done_d        = 1'b1;
                busy_d        = 1'b0;
                state_d       = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            a_r         <= '0;
            q_r         <= '0;
            m_r         <= '0;
            cnt_r       <= '0;
            q_neg_r     <= 1'b0;
            r_neg_r     <= 1'b0;
            dbz_r       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            a_r         <= a_d;
            q_r         <= q_d;
            m_r         <= m_d;
            cnt_r       <= cnt_d;
            q_neg_r     <= q_neg_d;
            r_neg_r     <= r_neg_d;
            dbz_r       <= dbz_d;
            busy        <= busy_d;
            done        <= done_d;
            quotient    <= quotient_d;
            remainder   <= remainder_d;
            div_by_zero <= div_by_zero_d;
        end
    end

endmodule

// File: tb/tb_nr_divider.sv
// Self-checking bench for nr_divider: a WIDTH=32 and a WIDTH=8 instance driven with
// directed and random operations, checked against a plain-arithmetic reference model.
module tb_nr_divider;

    logic        clk;
    logic        resetn;

    logic        start32, sgn32, busy32, done32, dbz32;
    logic [31:0] dvd32, dvs32, q32, r32;

    logic        start8, sgn8, busy8, done8, dbz8;
    logic [7:0]  dvd8, dvs8, q8, r8;

    int n_checks = 0;
    int n_fail   = 0;

    nr_divider #(.WIDTH(32)) dut32 (
        .clk(clk), .resetn(resetn), .start(start32), .signed_op(sgn32),
        .dividend(dvd32), .divisor(dvs32), .busy(busy32), .done(done32),
        .quotient(q32), .remainder(r32), .div_by_zero(dbz32)
    );

    nr_divider #(.WIDTH(8)) dut8 (
        .clk(clk), .resetn(resetn), .start(start8), .signed_op(sgn8),
        .dividend(dvd8), .divisor(dvs8), .busy(busy8), .done(done8),
        .quotient(q8), .remainder(r8), .div_by_zero(dbz8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Reference: sign-interpret operands in width w, divide with 64-bit arithmetic
    // (truncating division, remainder takes dividend's sign), truncate to w bits.
    function automatic void model(input int w, input bit sgn, input logic [31:0] a,
                                  input logic [31:0] b, output logic [31:0] q,
                                  output logic [31:0] r, output bit dbz);
        longint x, y, qq, rr;
        logic [31:0] mask;
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        x = 0;
        y = 0;
        x[31:0] = a & mask;
        y[31:0] = b & mask;
        if (sgn && x[w-1]) x = x - (longint'(1) << w);
        if (sgn && y[w-1]) y = y - (longint'(1) << w);
        if (y == 0) begin
            q   = mask;
            r   = a & mask;
            dbz = 1'b1;
        end else begin
            qq  = x / y;
            rr  = x % y;
            q   = qq[31:0] & mask;
            r   = rr[31:0] & mask;
            dbz = 1'b0;
        end
    endfunction

    function automatic logic cur_done(input bit w8);
        return w8 ? done8 : done32;
    endfunction
    function automatic logic cur_busy(input bit w8);
        return w8 ? busy8 : busy32;
    endfunction
    function automatic logic [31:0] cur_q(input bit w8);
        return w8 ? {24'd0, q8} : q32;
    endfunction
    function automatic logic [31:0] cur_r(input bit w8);
        return w8 ? {24'd0, r8} : r32;
    endfunction
    function automatic logic cur_dbz(input bit w8);
        return w8 ? dbz8 : dbz32;
    endfunction

    task automatic drive(input bit w8, input bit st, input bit sgn,
                         input logic [31:0] a, input logic [31:0] b);
        if (w8) begin
            start8 = st; sgn8 = sgn; dvd8 = a[7:0]; dvs8 = b[7:0];
        end else begin
            start32 = st; sgn32 = sgn; dvd32 = a; dvs32 = b;
        end
    endtask

    task automatic release_start();
        start8  = 1'b0;
        start32 = 1'b0;
    endtask

    // Issue one operation; must be called just after a falling edge. Returns at the
    // falling edge where done is seen, so the next call starts back-to-back.
    // poke: pulse start with different operands mid-operation.
    // full: also check busy duration, output hold and single-cycle done.
    task automatic run_op(input bit w8, input bit sgn, input logic [31:0] a,
                          input logic [31:0] b, input bit poke, input bit full);
        logic [31:0] eq, er, q0, r0;
        bit          edbz, seen, moved;
        int          lat, busy_cycles, w;
        string       id;
        w  = w8 ? 8 : 32;
        model(w, sgn, a, b, eq, er, edbz);
        id = $sformatf("w%0d s%0d 0x%0h/0x%0h", w, sgn, a, b);
        q0 = cur_q(w8);
        r0 = cur_r(w8);
        drive(w8, 1'b1, sgn, a, b);
        @(posedge clk);
        @(negedge clk);
        release_start();
        lat = 0; busy_cycles = 0; seen = 0; moved = 0;
        for (int i = 0; i < 60; i++) begin
            if (cur_done(w8)) begin
                seen = 1;
                break;
            end
            if (cur_busy(w8)) busy_cycles++;
            if (cur_q(w8) !== q0 || cur_r(w8) !== r0) moved = 1;
            if (poke && i == 4) drive(w8, 1'b1, ~sgn, ~a, b ^ 32'd1);
            if (poke && i == 5) release_start();
            @(negedge clk);
            lat++;
        end
        check({"done_seen ", id}, 32'(seen), 32'd1);
        check({"quotient ", id}, cur_q(w8), eq);
        check({"remainder ", id}, cur_r(w8), er);
        check({"div_by_zero ", id}, 32'(cur_dbz(w8)), 32'(edbz));
        check({"busy_with_done ", id}, 32'(cur_busy(w8)), 32'd0);
        check({"done_edge ", id}, 32'(lat), edbz ? 32'd1 : 32'(w + 1));
        if (full) begin
            check({"busy_cycles ", id}, 32'(busy_cycles), edbz ? 32'd1 : 32'(w + 1));
            check({"hold_until_done ", id}, 32'(moved), 32'd0);
            @(negedge clk);
            check({"done_pulse_width ", id}, 32'(cur_done(w8)), 32'd0);
        end
    endtask

    function automatic logic [31:0] pick(input int w);
        logic [31:0] mask, v;
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        case ($urandom_range(0, 7))
            0: v = 32'd0;
            1: v = 32'd1;
            2: v = mask;
            3: v = mask >> 1;
            4: v = (mask >> 1) + 32'd1;
            5: v = 32'($urandom_range(0, 15));
            default: v = $urandom();
        endcase
        return v & mask;
    endfunction

    initial begin
        resetn = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        repeat (3) @(negedge clk);
        check("reset_busy", 32'(busy32), 32'd0);
        check("reset_done", 32'(done32), 32'd0);
        check("reset_quotient", q32, 32'd0);
        check("reset_remainder", r32, 32'd0);
        check("reset_dbz", 32'(dbz32), 32'd0);
        resetn = 1'b1;
        @(negedge clk);

        // Directed 32-bit cases.
        run_op(1'b0, 1'b0, 32'd38, 32'd6, 1'b0, 1'b1);
        check("spec_38_div_6_q", q32, 32'd6);
        check("spec_38_div_6_r", r32, 32'd2);
        run_op(1'b0, 1'b1, 32'hFFFF_FFDA, 32'd6, 1'b0, 1'b1);
        check("spec_neg38_div_6_q", q32, 32'hFFFF_FFFA);
        run_op(1'b0, 1'b1, 32'd38, 32'hFFFF_FFFA, 1'b0, 1'b1);
        run_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1);
        check("spec_min_div_m1_q", q32, 32'h8000_0000);
        run_op(1'b0, 1'b0, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1'b1);
        check("spec_big_unsigned_r", r32, 32'h7FFF_FFFF);
        run_op(1'b0, 1'b0, 32'd1, 32'd50, 1'b0, 1'b1);
        run_op(1'b0, 1'b0, 32'h1234, 32'd0, 1'b0, 1'b1);
        check("spec_dbz_q", q32, 32'hFFFF_FFFF);
        run_op(1'b0, 1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
        run_op(1'b0, 1'b0, 32'd1000, 32'd7, 1'b1, 1'b1);

        // Abort mid-iteration: outputs clear, no done, and the next op is correct.
        drive(1'b0, 1'b1, 1'b0, 32'd99999, 32'd13);
        @(posedge clk);
        @(negedge clk);
        release_start();
        repeat (9) @(negedge clk);
        resetn = 1'b0;
        #1;
        check("abort_quotient", q32, 32'd0);
        check("abort_remainder", r32, 32'd0);
        check("abort_busy", 32'(busy32), 32'd0);
        begin
            bit saw_done;
            saw_done = 0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (i == 2) resetn = 1'b1;
                if (done32) saw_done = 1;
            end
            check("abort_no_done", 32'(saw_done), 32'd0);
        end
        run_op(1'b0, 1'b1, 32'hFFFF_8000, 32'd100, 1'b0, 1'b1);

        // Random 32-bit, back-to-back.
        for (int i = 0; i < 200; i++)
            run_op(1'b0, 1'($urandom_range(0, 1)), pick(32), pick(32), 1'b0, 1'b0);

        // WIDTH=8 corners then random.
        run_op(1'b1, 1'b0, 32'd38, 32'd6, 1'b0, 1'b1);
        run_op(1'b1, 1'b1, 32'h80, 32'hFF, 1'b0, 1'b1);
        run_op(1'b1, 1'b0, 32'hFF, 32'h80, 1'b0, 1'b1);
        run_op(1'b1, 1'b1, 32'h80, 32'h80, 1'b0, 1'b1);
        run_op(1'b1, 1'b1, 32'h85, 32'h00, 1'b0, 1'b1);
        run_op(1'b1, 1'b1, 32'h7F, 32'h81, 1'b0, 1'b1);
        for (int i = 0; i < 2500; i++)
            run_op(1'b1, 1'($urandom_range(0, 1)), pick(8), pick(8), 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
